// File: rtl/crc_dma_ctrl.sv
// Bus-mastering byte feeder for the CRC32 peripheral.
// Streams a memory buffer into the CRC unit and collects the result.
module crc_dma_ctrl #(
    parameter logic [31:0] CFG_BASE        = 32'h0000_0400,
    parameter logic [31:0] CRC_DATA_ADDR   = 32'h0000_0300,
    parameter logic [31:0] CRC_CTRL_ADDR   = 32'h0000_0304,
    parameter logic [31:0] CRC_STATUS_ADDR = 32'h0000_0308,
    parameter logic [31:0] CRC_RESULT_ADDR = 32'h0000_030C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_w_enable_i,
    input  logic [31:0] cfg_w_addr_i,
    input  logic        cfg_r_enable_i,
    input  logic [31:0] cfg_r_addr_i,
    input  logic [31:0] cfg_data_i,
    output logic [31:0] cfg_data_o,
    output logic        mem_r_enable_o,
    output logic [31:0] mem_r_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        crc_w_enable_o,
    output logic [31:0] crc_w_addr_o,
    output logic [31:0] crc_wdata_o,
    output logic        crc_r_enable_o,
    output logic [31:0] crc_r_addr_o,
    input  logic [31:0] crc_rdata_i,
    output logic        done_o
);

    typedef enum logic [3:0] {
        IDLE, SEED, FETCH, FWAIT, FEED,
        POLL, PWAIT, RREQ, RWAIT, CLR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q;
    logic [15:0] len_q;
    logic        chain_q;
    logic        done_q;
    logic [31:0] result_q;
    logic [31:0] ptr_q;
    logic [15:0] cnt_q;
    logic [31:0] wbuf_q;
    logic [7:0]  cur_byte;

    logic busy;
    logic wr_src, wr_len, wr_ctrl;
    logic rd_status;
    logic start_req;
    logic enter_idle;

    assign busy      = (state_q != IDLE);
    assign wr_src    = cfg_w_enable_i && (cfg_w_addr_i == CFG_BASE);
    assign wr_len    = cfg_w_enable_i && (cfg_w_addr_i == CFG_BASE + 32'h4);
    assign wr_ctrl   = cfg_w_enable_i && (cfg_w_addr_i == CFG_BASE + 32'h8);
    assign rd_status = cfg_r_enable_i && (cfg_r_addr_i == CFG_BASE + 32'hC);
    assign start_req = wr_ctrl && cfg_data_i[0] && !busy;
    assign done_o    = done_q;

    always_comb begin
        cur_byte = wbuf_q[7:0];
        unique case (ptr_q[1:0])
            2'd0: cur_byte = wbuf_q[7:0];
            2'd1: cur_byte = wbuf_q[15:8];
            2'd2: cur_byte = wbuf_q[23:16];
            2'd3: cur_byte = wbuf_q[31:24];
            default: cur_byte = wbuf_q[7:0];
        endcase
    end

    always_comb begin
        state_d        = state_q;
        mem_r_enable_o = 1'b0;
        mem_r_addr_o   = 32'h0;
        crc_w_enable_o = 1'b0;
        crc_w_addr_o   = 32'h0;
        crc_wdata_o    = 32'h0;
        crc_r_enable_o = 1'b0;
        crc_r_addr_o   = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (start_req && len_q != 16'h0)
                    state_d = SEED;
            end
            SEED: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = CRC_CTRL_ADDR;
                crc_wdata_o    = 32'h1;
                state_d        = FETCH;
            end
            FETCH: begin
                mem_r_enable_o = 1'b1;
                mem_r_addr_o   = {ptr_q[31:2], 2'b00};
                state_d        = FWAIT;
            end
            FWAIT: state_d = FEED;
            FEED: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = CRC_DATA_ADDR;
                crc_wdata_o    = {24'h0, cur_byte};
                state_d        = POLL;
            end
            POLL: begin
                crc_r_enable_o = 1'b1;
                crc_r_addr_o   = CRC_STATUS_ADDR;
                state_d        = PWAIT;
            end
            PWAIT: begin
                if (!crc_rdata_i[0])
                    state_d = POLL;
                else if (cnt_q != 16'h0)
                    state_d = (ptr_q[1:0] == 2'b00) ? FETCH : FEED;
                else
                    state_d = RREQ;
            end
            RREQ: begin
                crc_r_enable_o = 1'b1;
                crc_r_addr_o   = CRC_RESULT_ADDR;
                state_d        = RWAIT;
            end
            RWAIT: state_d = chain_q ? IDLE : CLR;
            CLR: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = CRC_CTRL_ADDR;
                crc_wdata_o    = 32'h0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_idle = busy && (state_d == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= 32'h0;
            len_q      <= 16'h0;
            chain_q    <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'h0;
            ptr_q      <= 32'h0;
            cnt_q      <= 16'h0;
            wbuf_q     <= 32'h0;
            cfg_data_o <= 32'h0;
        end else begin
            state_q <= state_d;
            if (!busy) begin
                if (wr_src)  src_q   <= cfg_data_i;
                if (wr_len)  len_q   <= cfg_data_i[15:0];
                if (wr_ctrl) chain_q <= cfg_data_i[1];
            end
            if (start_req && len_q != 16'h0) begin
                ptr_q <= src_q;
                cnt_q <= len_q;
            end
            if (state_q == FWAIT)
                wbuf_q <= mem_data_i;
            if (state_q == FEED) begin
                ptr_q <= ptr_q + 32'h1;
                cnt_q <= cnt_q - 16'h1;
            end
            if (state_q == RWAIT)
                result_q <= crc_rdata_i;
            // Completion beats both the read-to-clear and the start clear.
            if (rd_status || start_req)
                done_q <= 1'b0;
            if (enter_idle || (start_req && len_q == 16'h0))
                done_q <= 1'b1;
            if (cfg_r_enable_i) begin
                unique case (1'b1)
                    cfg_r_addr_i == CFG_BASE:
                        cfg_data_o <= src_q;
                    cfg_r_addr_i == CFG_BASE + 32'h4:
                        cfg_data_o <= {16'h0, len_q};
                    cfg_r_addr_i == CFG_BASE + 32'h8:
                        cfg_data_o <= {30'h0, chain_q, 1'b0};
                    cfg_r_addr_i == CFG_BASE + 32'hC:
                        cfg_data_o <= {30'h0, done_q & ~busy, busy};
                    cfg_r_addr_i == CFG_BASE + 32'h10:
                        cfg_data_o <= result_q;
                    default:
                        cfg_data_o <= 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_dma_ctrl.sv
// Directed bench for crc_dma_ctrl with a memory model and a
// CRC-32/MPEG-2 peripheral model that answers its bus traffic.
module tb_crc_dma_ctrl;

    localparam logic [31:0] BASE   = 32'h0000_0400;
    localparam logic [31:0] A_SRC  = BASE;
    localparam logic [31:0] A_LEN  = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;
    localparam logic [31:0] A_RES  = BASE + 32'h10;
    localparam logic [31:0] C_DATA = 32'h0000_0300;
    localparam logic [31:0] C_CTRL = 32'h0000_0304;
    localparam logic [31:0] C_STAT = 32'h0000_0308;
    localparam logic [31:0] C_RES  = 32'h0000_030C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_w_enable_i = 1'b0;
    logic [31:0] cfg_w_addr_i = 32'h0;
    logic        cfg_r_enable_i = 1'b0;
    logic [31:0] cfg_r_addr_i = 32'h0;
    logic [31:0] cfg_data_i = 32'h0;
    logic [31:0] cfg_data_o;
    logic        mem_r_enable_o;
    logic [31:0] mem_r_addr_o;
    logic [31:0] mem_data_i = 32'h0;
    logic        crc_w_enable_o;
    logic [31:0] crc_w_addr_o;
    logic [31:0] crc_wdata_o;
    logic        crc_r_enable_o;
    logic [31:0] crc_r_addr_o;
    logic [31:0] crc_rdata_i = 32'h0;
    logic        done_o;

    crc_dma_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_w_enable_i(cfg_w_enable_i), .cfg_w_addr_i(cfg_w_addr_i),
        .cfg_r_enable_i(cfg_r_enable_i), .cfg_r_addr_i(cfg_r_addr_i),
        .cfg_data_i(cfg_data_i), .cfg_data_o(cfg_data_o),
        .mem_r_enable_o(mem_r_enable_o), .mem_r_addr_o(mem_r_addr_o),
        .mem_data_i(mem_data_i),
        .crc_w_enable_o(crc_w_enable_o), .crc_w_addr_o(crc_w_addr_o),
        .crc_wdata_o(crc_wdata_o),
        .crc_r_enable_o(crc_r_enable_o), .crc_r_addr_o(crc_r_addr_o),
        .crc_rdata_i(crc_rdata_i), .done_o(done_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] crc_state = 32'hFFFF_FFFF;
    logic        complete = 1'b0;
    logic        ok_to_write = 1'b1;
    int          busy_cnt = 0;
    int          stall_byte = -1;
    int          n_mem = 0, n_data = 0, n_ctrl0 = 0, n_stat = 0, n_viol = 0;
    logic [31:0] last_ctrl = 32'hDEAD_BEEF;
    logic [31:0] mem_addr_q [$];
    logic [7:0]  byte_q [$];
    int          checks = 0, fails = 0;

    function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
        end
        return c;
    endfunction

    // Memory and CRC peripheral models.
    always @(posedge clk) begin
        if (!rst_n) begin
            crc_state   <= 32'hFFFF_FFFF;
            complete    <= 1'b0;
            ok_to_write <= 1'b1;
            busy_cnt    <= 0;
            crc_rdata_i <= 32'h0;
        end else begin
            if (mem_r_enable_o) begin
                mem_data_i <= mem[mem_r_addr_o[9:2]];
                n_mem = n_mem + 1;
                mem_addr_q.push_back(mem_r_addr_o);
            end
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) complete <= 1'b1;
            end
            if (crc_w_enable_o && crc_w_addr_o == C_DATA) begin
                if (!ok_to_write) n_viol = n_viol + 1;
                crc_state   <= crc_byte(crc_state, crc_wdata_o[7:0]);
                ok_to_write <= 1'b0;
                complete    <= 1'b0;
                busy_cnt    <= (n_data == stall_byte) ? 20 : 2;
                byte_q.push_back(crc_wdata_o[7:0]);
                n_data = n_data + 1;
            end
            if (crc_w_enable_o && crc_w_addr_o == C_CTRL) begin
                last_ctrl = crc_wdata_o;
                if (!crc_wdata_o[0]) begin
                    crc_state <= 32'hFFFF_FFFF;
                    n_ctrl0 = n_ctrl0 + 1;
                end
            end
            if (crc_r_enable_o) begin
                if (crc_r_addr_o == C_STAT) begin
                    crc_rdata_i <= {31'h0, complete};
                    n_stat = n_stat + 1;
                    if (complete) begin
                        ok_to_write <= 1'b1;
                        complete    <= 1'b0;
                    end
                end else if (crc_r_addr_o == C_RES) begin
                    crc_rdata_i <= crc_state;
                end else begin
                    crc_rdata_i <= 32'h0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_w_enable_i = 1'b1;
        cfg_w_addr_i   = a;
        cfg_data_i     = d;
        @(negedge clk);
        cfg_w_enable_i = 1'b0;
    endtask

    task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_r_enable_i = 1'b1;
        cfg_r_addr_i   = a;
        @(negedge clk);
        cfg_r_enable_i = 1'b0;
        d = cfg_data_o;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while (!done_o && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, done_o}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        int m0, d0, c0, s0, q0, b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h3433_3231;
        mem[8'h41] = 32'h3837_3635;
        mem[8'h42] = 32'h0000_0039;
        mem[8'h80] = 32'h3433_3231;
        mem[8'h84] = 32'h3837_3635;
        mem[8'h85] = 32'h0000_0039;

        repeat (3) @(negedge clk);
        chk("reset_outs",
            {27'h0, done_o, mem_r_enable_o, crc_w_enable_o,
             crc_r_enable_o, |cfg_data_o}, 32'h0);
        rst_n = 1'b1;
        cfg_read(A_SRC, rd);
        chk("reset_src", rd, 32'h0);
        cfg_read(A_STAT, rd);
        chk("reset_status", rd, 32'h0);

        // Aligned 9-byte job.
        m0 = n_mem; d0 = n_data; c0 = n_ctrl0;
        cfg_write(A_SRC, 32'h100);
        cfg_write(A_LEN, 32'd9);
        cfg_write(A_CTRL, 32'h1);
        cfg_read(A_STAT, rd);
        chk("status_busy", rd, 32'h1);
        wait_done("job9_done", 400);
        cfg_read(A_RES, rd);
        chk("job9_result", rd, 32'h0376_E6E7);
        chk("job9_mem_reads", n_mem - m0, 3);
        chk("job9_data_writes", n_data - d0, 9);
        chk("job9_ctrl_clear", n_ctrl0 - c0, 1);
        chk("job9_last_ctrl", last_ctrl, 32'h0);
        cfg_read(A_STAT, rd);
        chk("status_done", rd, 32'h2);
        cfg_read(A_STAT, rd);
        chk("status_rc", rd, 32'h0);
        chk("done_cleared", {31'h0, done_o}, 32'h0);

        // Zero-length start.
        m0 = n_mem; d0 = n_data; s0 = n_stat; c0 = n_ctrl0;
        cfg_write(A_LEN, 32'h0);
        cfg_write(A_CTRL, 32'h1);
        wait_done("len0_done", 2);
        cfg_read(A_RES, rd);
        chk("len0_result", rd, 32'h0376_E6E7);
        chk("len0_traffic", (n_mem - m0) + (n_data - d0) + (n_stat - s0)
            + (n_ctrl0 - c0), 0);
        cfg_read(A_STAT, rd);

        // Unaligned two-byte job.
        q0 = mem_addr_q.size(); b0 = byte_q.size(); m0 = n_mem;
        cfg_write(A_SRC, 32'h103);
        cfg_write(A_LEN, 32'd2);
        cfg_write(A_CTRL, 32'h1);
        wait_done("unal_done", 200);
        chk("unal_reads", n_mem - m0, 2);
        if (mem_addr_q.size() >= q0 + 2 && byte_q.size() >= b0 + 2) begin
            chk("unal_addr0", mem_addr_q[q0], 32'h100);
            chk("unal_addr1", mem_addr_q[q0 + 1], 32'h104);
            chk("unal_byte0", {24'h0, byte_q[b0]}, 32'h34);
            chk("unal_byte1", {24'h0, byte_q[b0 + 1]}, 32'h35);
        end else begin
            chk("unal_logs", mem_addr_q.size() + byte_q.size(),
                q0 + b0 + 4);
        end
        cfg_read(A_STAT, rd);

        // Chained pair "1234" + "56789".
        c0 = n_ctrl0;
        cfg_write(A_SRC, 32'h200);
        cfg_write(A_LEN, 32'd4);
        cfg_write(A_CTRL, 32'h3);
        wait_done("chainA_done", 200);
        chk("chain_no_clear", n_ctrl0 - c0, 0);
        cfg_read(A_STAT, rd);
        cfg_write(A_SRC, 32'h210);
        cfg_write(A_LEN, 32'd5);
        cfg_write(A_CTRL, 32'h1);
        wait_done("chainB_done", 200);
        cfg_read(A_RES, rd);
        chk("chain_result", rd, 32'h0376_E6E7);
        chk("chainB_clear", n_ctrl0 - c0, 1);
        cfg_read(A_STAT, rd);

        // Stalled first byte.
        d0 = n_data; s0 = n_stat;
        stall_byte = n_data;
        cfg_write(A_SRC, 32'h100);
        cfg_write(A_LEN, 32'd9);
        cfg_write(A_CTRL, 32'h1);
        wait_done("stall_done", 600);
        cfg_read(A_RES, rd);
        chk("stall_result", rd, 32'h0376_E6E7);
        chk("stall_writes", n_data - d0, 9);
        chk("stall_polls", {31'h0, (n_stat - s0) >= 17}, 32'h1);
        chk("no_early_write", n_viol, 0);
        cfg_read(A_STAT, rd);

        // Busy write ignore, then reset mid-job.
        c0 = n_ctrl0;
        cfg_write(A_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        cfg_write(A_SRC, 32'hFFFF);
        cfg_read(A_SRC, rd);
        chk("busy_src_kept", rd, 32'h100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_strobes",
            {28'h0, done_o, mem_r_enable_o, crc_w_enable_o,
             crc_r_enable_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_read(A_STAT, rd);
        chk("rst_status", rd, 32'h0);
        repeat (5) @(negedge clk);
        chk("rst_no_clear", n_ctrl0 - c0, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/crc_dma_ctrl.md
Name: crc_dma_ctrl

Overview:
- Bus-mastering sequencer for the memory-mapped CRC32 peripheral.
- Software programs a source address and byte count, then sets start. The block reads the bytes from data memory and feeds them one at a time to the CRC data register.
- For each byte it polls the CRC status register until the byte completes. When the buffer is finished it reads back the result and raises done.
- Sits on the peripheral bus beside the CRC unit: slave on a config port, master on the memory and CRC ports.

Parameters:
- CFG_BASE, 32'h0000_0400: base of the block's own register window.
- CRC_DATA_ADDR, 32'h0000_0300: CRC data register address.
- CRC_CTRL_ADDR, 32'h0000_0304: CRC control register address (bit0 = continue).
- CRC_STATUS_ADDR, 32'h0000_0308: CRC status register (bit0 = complete, cleared by read).
- CRC_RESULT_ADDR, 32'h0000_030C: CRC result register.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- cfg_w_enable_i  in  1  config write strobe (`write_enable)
- cfg_w_addr_i  in  `mem_addr_bus  config write address
- cfg_r_enable_i  in  1  config read strobe (`read_enable)
- cfg_r_addr_i  in  `mem_addr_bus  config read address
- cfg_data_i  in  `data_bus  config write data
- cfg_data_o  out  `data_bus  config read data, registered
- mem_r_enable_o  out  1  memory read strobe
- mem_r_addr_o  out  `mem_addr_bus  word-aligned memory read address
- mem_data_i  in  `data_bus  memory read data, valid 1 cycle after the strobe
- crc_w_enable_o  out  1  CRC write strobe
- crc_w_addr_o  out  `mem_addr_bus  CRC write address
- crc_wdata_o  out  `data_bus  CRC write data
- crc_r_enable_o  out  1  CRC read strobe
- crc_r_addr_o  out  `mem_addr_bus  CRC read address
- crc_rdata_i  in  `data_bus  CRC read data, valid 1 cycle after the address
- done_o  out  1  level; mirrors STATUS.done

Behaviour:
- Register map (offsets from CFG_BASE):
  - 0x0 SRC: 32-bit byte address, R/W.
  - 0x4 LEN: bits[15:0] byte count, R/W.
  - 0x8 CTRL:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 CHAIN: R/W; 1 keeps the CRC seed across jobs.
  - 0xC STATUS:
    - bit0 BUSY.
    - bit1 DONE: cleared by a cfg read of STATUS, unless it is being set in the same cycle (set wins).
  - 0x10 RESULT: R.
- Config reads are registered with 1-cycle latency. Unmapped addresses read 0.
- Writes to SRC, LEN and CTRL while BUSY are ignored.
- Reset values:
  - All outputs 0.
  - SRC, LEN, CHAIN, DONE 0; RESULT 32'h0.
  - FSM in IDLE.
- FSM states and transitions:
  - IDLE:
    - START with LEN≠0: latch ptr=SRC, cnt=LEN, set BUSY, go to SEED.
    - START with LEN=0: set DONE next cycle, no bus traffic, stay in IDLE.
  - SEED: write CRC_CTRL_ADDR ← 1 (continue), 1 cycle. Go to FETCH.
  - FETCH: mem_r_enable_o=1, mem_r_addr_o={ptr[31:2],2'b00}. Go to FWAIT.
  - FWAIT: latch the word into wbuf. Go to FEED.
  - FEED:
    - Write CRC_DATA_ADDR ← {24'b0, byte}, where byte = wbuf lane ptr[1:0] (little-endian: lane0 = bits[7:0]).
    - ptr+1, cnt-1. Go to POLL.
  - POLL: crc_r_enable_o=1, crc_r_addr_o=CRC_STATUS_ADDR. Go to PWAIT.
  - PWAIT:
    - crc_rdata_i[0]=0: back to POLL.
    - bit0=1 and cnt≠0: go to FETCH if the new ptr[1:0]==0, else FEED (reuse wbuf).
    - bit0=1 and cnt=0: go to RREQ.
  - RREQ: read CRC_RESULT_ADDR. Go to RWAIT.
  - RWAIT: latch crc_rdata_i into RESULT.
    - CHAIN=1: go to IDLE.
    - CHAIN=0: go to CLR.
  - CLR: write CRC_CTRL_ADDR ← 0 to re-seed the CRC. Go to IDLE.
  - DONE is set and BUSY cleared on the transition into IDLE.
- Handshake and timing rules:
  - Every CRC/memory strobe is exactly one cycle wide.
  - A CRC data write is never issued before the previous byte's complete bit has been read as 1.
  - At most one memory read per aligned word: unaligned SRC fetches the first word once, then refetches at each word boundary.
- Arithmetic:
  - ptr wraps modulo 2^32.
  - cnt is a 16-bit down-counter; max LEN = 65535.
- Status polling: a STATUS read while BUSY returns BUSY=1, DONE=0.
- Reset mid-job: the FSM returns to IDLE and all strobes drop the same cycle. No CTRL clear write is issued; the CRC unit's own reset re-seeds it.

Test Plan:
- SRC=0x100 holding "123456789" (bytes 0x31..0x39, little-endian words), LEN=9, CHAIN=0, START -> RESULT=32'h0376E6E7, DONE=1, exactly 3 memory reads, 9 CRC data writes, final CRC_CTRL write of 0.
- LEN=0, START -> DONE=1 within 2 cycles, RESULT unchanged, zero mem/CRC strobes.
- Unaligned run: SRC=0x103, LEN=2 -> memory reads at 0x100 then 0x104; bytes fed are lane3 of word 0x100, then lane0 of word 0x104.
- Chaining: "1234" with CHAIN=1, then "56789" with CHAIN=0 -> second RESULT=32'h0376E6E7; no CTRL clear between the jobs.
- Stall: hold the CRC status bit0 low for 20 cycles -> the FSM keeps polling, no new data write; completes correctly afterward.
- Write SRC=0xFFFF while BUSY, and assert rst_n=0 mid-job -> SRC keeps its old value; after reset, BUSY=0, DONE=0, all strobes 0.
